// File: rtl/serial_pkg.sv
// serial_pkg: state encoding and sizing shared by the bit-serial adder.
package serial_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
    localparam int DEF_WIDTH = 16;
    function automatic int cnt_w(input int w);
        return w < 2 ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/serial_adder16_fa.sv
// full_adder_bit: one full-adder cell from two Xor gates and an And/Or majority.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p, g, t;
    xor u_x0 (p, a, b);
    xor u_x1 (s, p, cin);
    and u_a0 (g, a, b);
    and u_a1 (t, p, cin);
    or  u_o0 (cout, g, t);
endmodule

// File: rtl/serial_adder16.sv
// serial_adder16: LSB-first bit-serial adder, one bit per clock through a single full adder.
import serial_pkg::*;
module serial_adder16 #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = cnt_w(WIDTH);
    state_e state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q, res_d;
    logic [WIDTH-2:0] res_q;
    logic [CW-1:0] cnt_q;
    logic c_q, carry_q, s, cout, last, load;
    full_adder_bit u_fa (.a(a_q[0]), .b(b_q[0]), .cin(c_q), .s(s), .cout(cout));
    assign last  = cnt_q == CW'(WIDTH - 1);
    assign load  = start && state_q != RUN;
    // res_d is the result register after this cycle's shift; its full width is the finished sum
    assign res_d = {s, res_q};
    assign busy  = state_q == RUN;
    assign done  = state_q == DONE;
    assign sum   = sum_q;
    assign carry = carry_q;
    always_comb begin
        state_d = state_q;
        state_d = state_q == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_q   <= a;
                b_q   <= b;
                c_q   <= 1'b0;
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                a_q   <= a_q >> 1;
                b_q   <= b_q >> 1;
                c_q   <= cout;
                res_q <= res_d[WIDTH-1:1];
                cnt_q <= last ? cnt_q : cnt_q + CW'(1);
                if (last) begin
                    sum_q   <= res_d;
                    carry_q <= cout;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder16.sv
// tb_serial_adder16: directed checks of the bit-serial adder with hand-computed results.
module tb_serial_adder16;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] a = '0, b = '0, sum;
    logic busy, done, carry;
    int total = 0, bad = 0;
    serial_adder16 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .carry(carry)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic wait_done(output int n, output int nb, output bit stable);
        logic [15:0] s0;
        logic c0;
        s0 = sum;
        c0 = carry;
        n = 0;
        nb = 0;
        stable = 1'b1;
        while (!done && n < 40) begin
            if (busy) nb++;
            if (sum !== s0 || carry !== c0) stable = 1'b0;
            step;
            n++;
        end
    endtask
    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] es, input logic ec);
        int n, nb;
        bit st;
        a = x;
        b = y;
        start = 1'b1;
        step;
        start = 1'b0;
        wait_done(n, nb, st);
        chk({tag, "_latency"}, n, 16);
        chk({tag, "_busy_cycles"}, nb, 16);
        chk({tag, "_stable_in_run"}, st, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_carry"}, carry, ec);
        step;
        chk({tag, "_done_one_cycle"}, done, 0);
    endtask
    initial begin
        int n, nb, cnt;
        bit st;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sum", sum, 0);
        chk("reset_carry", carry, 0);
        #13 rst_n = 1'b1;
        step;
        run_op("zero", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        run_op("mix", 16'h1234, 16'h4321, 16'h5555, 1'b0);
        run_op("one", 16'h0001, 16'h0001, 16'h0002, 1'b0);
        run_op("ovf1", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        run_op("ovf2", 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);
        // start during RUN and wiggling operands must not disturb the addition
        a = 16'h00FF;
        b = 16'h0001;
        start = 1'b1;
        step;
        for (int i = 1; i <= 10; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            start = 1'b0;
            if (i == 5) begin
                a = 16'hAAAA;
                b = 16'h5555;
                start = 1'b1;
            end
            step;
        end
        start = 1'b0;
        wait_done(n, nb, st);
        chk("ign_latency", n, 6);
        chk("ign_sum", sum, 16'h0100);
        chk("ign_carry", carry, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step;
            if (done || busy) cnt++;
        end
        chk("ign_no_requeue", cnt, 0);
        // asynchronous reset mid-operation
        a = 16'h1234;
        b = 16'h1111;
        start = 1'b1;
        step;
        start = 1'b0;
        repeat (8) step;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sum", sum, 0);
        chk("arst_carry", carry, 0);
        step;
        step;
        #3 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step;
            if (done) cnt++;
        end
        chk("arst_no_done", cnt, 0);
        chk("arst_sum_after", sum, 0);
        run_op("post_rst", 16'h0003, 16'h0004, 16'h0007, 1'b0);
        // back-to-back: start held through the DONE cycle
        a = 16'h1234;
        b = 16'h4321;
        start = 1'b1;
        step;
        start = 1'b0;
        wait_done(n, nb, st);
        chk("b2b_first_done", done, 1);
        chk("b2b_first_sum", sum, 16'h5555);
        a = 16'h8000;
        b = 16'h8000;
        start = 1'b1;
        step;
        start = 1'b0;
        chk("b2b_no_idle", busy, 1);
        wait_done(n, nb, st);
        chk("b2b_done_gap", n + 1, 17);
        chk("b2b_sum", sum, 16'h0000);
        chk("b2b_carry", carry, 1);
        step;
        chk("b2b_done_one_cycle", done, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
